layout_unskew: RTL and testbench
================================

Name: layout_unskew

Overview:
Inverse of the layoutB skew stage. It accepts diagonal wavefronts streamed out of the systolic array, one wavefront per handshake. It de-skews them into a row-major n x p feature map held in an internal DIM x DIM buffer. It then streams the map out one row per handshake to the feature-map writeback path.

Parameters:
BITS, 8, bit width of each pixel
DIM, 32, maximum feature-map dimension; lane count of the input and output vectors

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse that begins a frame; n_in and p_in are sampled on this cycle
n_in  input  $clog2(DIM)+1  row count n of the frame
p_in  input  $clog2(DIM)+1  column count p of the frame
in_valid  input  1  in_vec holds a valid wavefront
in_ready  output  1  block accepts a wavefront this cycle
in_vec  input  [DIM-1:0][BITS-1:0]  wavefront; lane j is column j
out_valid  output  1  out_row holds a valid row
out_ready  input  1  downstream accepts the row
out_row  output  [DIM-1:0][BITS-1:0]  row data; lane j is column j
out_row_idx  output  $clog2(DIM)  index of the row currently presented
out_last  output  1  presented row is row n-1
busy  output  1  FSM is not in IDLE
done  output  1  one-cycle pulse after the last row is accepted
err  output  1  one-cycle pulse when start is rejected

Behaviour:
- Reset, asynchronous on rst_n=0:
  - FSM goes to IDLE; wavefront counter k, row counter r, latched n and p all clear to 0.
  - in_ready, out_valid, out_last, busy, done and err are 0; out_row_idx is 0.
  - The buffer is not cleared.
  - Reset mid-frame abandons the frame; no done pulse is issued.
- FSM states: IDLE, COLLECT, DRAIN.
- IDLE:
  - On start with 1<=n_in<=DIM and 1<=p_in<=DIM: latch n and p, set k=0, go to COLLECT next cycle.
  - On start with any other n_in or p_in: pulse err for one cycle the next cycle and stay in IDLE.
- COLLECT:
  - in_ready=1 (registered state decode, no combinational path from in_valid).
  - On in_valid&&in_ready, wavefront k writes buf[k-j][j] = in_vec[j] for every lane j<p with 0<=k-j<n. All other lanes are ignored.
  - k increments on each accepted wavefront.
  - When wavefront k = n+p-2 is accepted, the next state is DRAIN with r=0.
  - Total accepted wavefronts = n+p-1; in_valid while not in COLLECT is ignored.
- DRAIN:
  - out_valid=1.
  - out_row[j] = buf[r][j] for j<p; lanes j>=p are driven 0.
  - out_row_idx=r; out_last=(r==n-1).
  - out_row, out_row_idx and out_last are held stable while out_valid&&!out_ready.
  - On out_valid&&out_ready: r increments.
  - On the handshake with r=n-1: go to IDLE and pulse done in the following cycle.
- Latency: the first row is presented the cycle after the final wavefront is accepted. Full throughput is one wavefront per cycle in and one row per cycle out.
- A start pulse while busy is ignored and does not raise err.
- A collect/drain overlap is not supported; the next frame may start the cycle done is high.
- Counter widths: k is $clog2(2*DIM) bits; all comparisons are done at that width with no wrap. The n=p=DIM case needs 2*DIM-1 wavefronts.
- n=1 or p=1 is legal: p wavefronts for n=1, n wavefronts for p=1.

Test Plan:
- DIM=4, BITS=8, start n=2 p=2, wavefronts {lane0=0x11}, {0x21,0x12}, {x,0x22} -> rows [0x11,0x12,0,0] then [0x21,0x22,0,0]; out_row_idx 0 then 1, out_last on row 1, done one cycle after.
- DIM=32, n=p=32, random matrix skewed exactly as layoutB does (63 wavefronts, in_valid every cycle) -> 32 rows equal to the original matrix. First out_valid the cycle after wavefront 62 is accepted.
- n=14 p=5 with in_valid gapped randomly and out_ready toggled randomly -> data correct; out_row stable across every stall; exactly 18 wavefronts consumed.
- start with n_in=0, then with p_in=33 (DIM=32) -> err pulse each time, busy stays 0, in_ready stays 0.
- Reset asserted after 3 wavefronts of an n=5 p=5 frame -> all outputs 0 immediately, no done. A new n=5 p=5 frame then completes correctly.
- start asserted during DRAIN -> ignored, no err; the frame finishes normally and a start the cycle done is high is accepted.

Source files
------------

// File: rtl/layout_unskew.sv
// De-skews diagonal wavefronts from the systolic array into a row-major buffer,
// then streams the buffered n x p feature map out one row per handshake.
module layout_unskew #(
  parameter int BITS = 8,
  parameter int DIM  = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [$clog2(DIM):0]           n_in,
  input  logic [$clog2(DIM):0]           p_in,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DIM-1:0][BITS-1:0]       in_vec,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DIM-1:0][BITS-1:0]       out_row,
  output logic [$clog2(DIM)-1:0]         out_row_idx,
  output logic                           out_last,
  output logic                           busy,
  output logic                           done,
  output logic                           err
);

  localparam int NW = $clog2(DIM) + 1;
  localparam int RW = $clog2(DIM);
  localparam int KW = $clog2(2 * DIM);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DRAIN
  } state_e;

  state_e          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [RW-1:0]   r_q, r_d;
  logic [NW-1:0]   n_q, n_d;
  logic [NW-1:0]   p_q, p_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic            start_ok;
  logic            last_wf;
  logic            last_row;
  logic            accept;

  assign start_ok = (n_in != '0) && (n_in <= NW'(DIM)) &&
                    (p_in != '0) && (p_in <= NW'(DIM));
  assign last_wf  = (k_q == (KW'(n_q) + KW'(p_q) - KW'(2)));
  assign last_row = ({1'b0, r_q} == (n_q - NW'(1)));
  assign accept   = (state_q == COLLECT) && in_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      r_q     <= '0;
      n_q     <= '0;
      p_q     <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      r_q     <= r_d;
      n_q     <= n_d;
      p_q     <= p_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    r_d     = r_q;
    n_d     = n_q;
    p_d     = p_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (start_ok) begin
            n_d     = n_in;
            p_d     = p_in;
            k_d     = '0;
            state_d = COLLECT;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      COLLECT: begin
        if (in_valid) begin
          k_d = k_q + KW'(1);
          if (last_wf) begin
            state_d = DRAIN;
            r_d     = '0;
          end
        end
      end
      DRAIN: begin
        if (out_ready) begin
          r_d = r_q + RW'(1);
          if (last_row) begin
            state_d = IDLE;
            done_d  = 1'b1;
            r_d     = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Each lane owns one buffer column: wavefront k places lane j at row k-j,
  // so the buffer is split per column and each column has a single writer.
  for (genvar j = 0; j < DIM; j++) begin : g_lane
    logic [BITS-1:0] col_q [DIM];
    logic [KW:0]     diff;
    logic            wr_en;

    assign diff  = {1'b0, k_q} - (KW + 1)'(j);
    assign wr_en = accept && (KW'(j) < KW'(p_q)) && !diff[KW] &&
                   (diff[KW-1:0] < KW'(n_q));

    always_ff @(posedge clk) begin
      if (wr_en) begin
        col_q[diff[RW-1:0]] <= in_vec[j];
      end
    end

    assign out_row[j] = ((state_q == DRAIN) && (KW'(j) < KW'(p_q))) ?
                        col_q[r_q] : '0;
  end

  assign in_ready    = (state_q == COLLECT);
  assign out_valid   = (state_q == DRAIN);
  assign out_last    = (state_q == DRAIN) && last_row;
  assign out_row_idx = r_q;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_layout_unskew.sv
// Directed bench for layout_unskew: skews a reference matrix into wavefronts
// and checks the de-skewed rows, handshakes, pulses and error handling.
module tb_layout_unskew;

  localparam int BITS = 8;
  localparam int DIM  = 32;
  localparam int NW   = 6;
  localparam int RW   = 5;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b1;
  logic                     start = 1'b0;
  logic [NW-1:0]            n_in = '0;
  logic [NW-1:0]            p_in = '0;
  logic                     in_valid = 1'b0;
  logic                     in_ready;
  logic [DIM-1:0][BITS-1:0] in_vec = '0;
  logic                     out_valid;
  logic                     out_ready = 1'b0;
  logic [DIM-1:0][BITS-1:0] out_row;
  logic [RW-1:0]            out_row_idx;
  logic                     out_last;
  logic                     busy;
  logic                     done;
  logic                     err;

  int checks = 0;
  int errors = 0;
  logic [BITS-1:0] mat [DIM][DIM];

  always #5 clk = ~clk;

  layout_unskew #(.BITS(BITS), .DIM(DIM)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .n_in(n_in), .p_in(p_in),
    .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
    .out_row_idx(out_row_idx), .out_last(out_last), .busy(busy),
    .done(done), .err(err)
  );

  task automatic fill_mat();
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++)
        mat[i][j] = BITS'($urandom);
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 ||
        done !== 1'b0 || err !== 1'b0 || out_row_idx !== '0 || out_row !== '0) begin
      errors++;
      $display("FAIL %s: in_ready=%b out_valid=%b out_last=%b busy=%b done=%b err=%b idx=%0d row_nonzero=%b, required all 0",
               name, in_ready, out_valid, out_last, busy, done, err, out_row_idx, (out_row != '0));
    end
  endtask

  task automatic do_start(input int n, input int p);
    start = 1'b1;
    n_in  = NW'(n);
    p_in  = NW'(p);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic feed(input int n, input int p, input int count, input bit gapped);
    int k = 0;
    int cyc = 0;
    logic [DIM-1:0][BITS-1:0] v;
    while (k < count && cyc < 2000) begin
      for (int j = 0; j < DIM; j++) begin
        if (k - j >= 0 && k - j < n && j < p) v[j] = mat[k-j][j];
        else v[j] = BITS'($urandom);
      end
      in_vec   = v;
      in_valid = gapped ? ($urandom_range(0, 2) != 0) : 1'b1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL collect_state: wavefront %0d in_ready=%b out_valid=%b, required 1/0",
                 k, in_ready, out_valid);
      end
      @(negedge clk);
      if (in_valid) k++;
      cyc++;
    end
    if (k < count) begin
      checks++;
      errors++;
      $display("FAIL feed_timeout: accepted %0d wavefronts, required %0d", k, count);
    end
    if (count == n + p - 1) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL first_row_latency: out_valid=%b in_ready=%b, required 1/0", out_valid, in_ready);
      end
      // Keep offering junk wavefronts: they must not be consumed.
      in_valid = 1'b1;
      for (int j = 0; j < DIM; j++) v[j] = BITS'($urandom);
      in_vec = v;
    end else begin
      in_valid = 1'b0;
    end
  endtask

  task automatic drain(input int n, input int p, input bit stall, input bit inject);
    int r = 0;
    int cyc = 0;
    bit was_stall = 1'b0;
    logic [DIM-1:0][BITS-1:0] exp_row;
    logic [DIM-1:0][BITS-1:0] held;
    while (r < n && cyc < 2000) begin
      for (int j = 0; j < DIM; j++) exp_row[j] = (j < p) ? mat[r][j] : '0;
      checks++;
      if (out_valid !== 1'b1 || out_row !== exp_row || out_row_idx !== RW'(r) ||
          out_last !== (r == n - 1) || err !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL drain_row%0d: valid=%b idx=%0d last=%b err=%b busy=%b rdy=%b row=%h, required row=%h",
                 r, out_valid, out_row_idx, out_last, err, busy, in_ready, out_row, exp_row);
      end
      if (was_stall) begin
        checks++;
        if (out_row !== held) begin
          errors++;
          $display("FAIL stall_hold: row=%h, required %h", out_row, held);
        end
      end
      held      = out_row;
      start     = inject && (cyc == 0);
      n_in      = NW'(2);
      p_in      = NW'(2);
      out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      was_stall = !out_ready;
      @(negedge clk);
      if (out_ready) r++;
      cyc++;
    end
    start     = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    if (r < n) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: rows accepted %0d, required %0d", r, n);
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse: done=%b busy=%b out_valid=%b err=%b, required 1/0/0/0",
               done, busy, out_valid, err);
    end
  endtask

  task automatic done_falls();
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_width: done=%b busy=%b, required 0/0", done, busy);
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset_state");
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("after_reset_release");
  endtask

  task automatic test_small();
    mat[0][0] = 8'h11; mat[0][1] = 8'h12;
    mat[1][0] = 8'h21; mat[1][1] = 8'h22;
    do_start(2, 2);
    feed(2, 2, 3, 1'b0);
    drain(2, 2, 1'b0, 1'b0);
    done_falls();
  endtask

  task automatic test_full();
    fill_mat();
    do_start(32, 32);
    feed(32, 32, 63, 1'b0);
    drain(32, 32, 1'b0, 1'b0);
    done_falls();
  endtask

  task automatic test_gapped();
    fill_mat();
    do_start(14, 5);
    feed(14, 5, 18, 1'b1);
    drain(14, 5, 1'b1, 1'b0);
    done_falls();
  endtask

  task automatic test_err();
    do_start(0, 3);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL err_n0: err=%b busy=%b in_ready=%b, required 1/0/0", err, busy, in_ready);
    end
    @(negedge clk);
    checks++;
    if (err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL err_n0_width: err=%b busy=%b, required 0/0", err, busy);
    end
    do_start(4, 33);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL err_p33: err=%b busy=%b in_ready=%b, required 1/0/0", err, busy, in_ready);
    end
    @(negedge clk);
    checks++;
    if (err !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL err_p33_width: err=%b busy=%b in_ready=%b, required 0/0/0", err, busy, in_ready);
    end
  endtask

  task automatic test_mid_reset();
    fill_mat();
    do_start(5, 5);
    feed(5, 5, 3, 1'b0);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("async_reset_midframe");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check_idle_outputs("no_done_after_reset");
    end
    fill_mat();
    do_start(5, 5);
    feed(5, 5, 9, 1'b0);
    drain(5, 5, 1'b0, 1'b0);
    done_falls();
  endtask

  task automatic test_back_to_back();
    fill_mat();
    do_start(3, 4);
    feed(3, 4, 6, 1'b0);
    drain(3, 4, 1'b0, 1'b1);
    fill_mat();
    do_start(4, 3);
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL start_on_done: busy=%b in_ready=%b err=%b, required 1/1/0", busy, in_ready, err);
    end
    feed(4, 3, 6, 1'b0);
    drain(4, 3, 1'b1, 1'b0);
    done_falls();
  endtask

  initial begin
    test_reset();
    test_small();
    test_full();
    test_gapped();
    test_err();
    test_mid_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
